// File: rtl/rv32_mem_pkg.sv
// Shared MEM-stage definitions for the RV32 data path.
// Contents:
//   BE_BYTE / BE_HALF / BE_WORD : lane-0 aligned store/load byte enables
//   sb_entry_t                  : one buffered store (word address, byte offset, data, enables)
//   load_type_t                 : load encodings shared with the data extender
//   align_be()                  : moves a lane-0 byte enable onto the lanes selected by addr[1:0]
package rv32_mem_pkg;

    localparam logic [3:0] BE_BYTE = 4'h1;
    localparam logic [3:0] BE_HALF = 4'h3;
    localparam logic [3:0] BE_WORD = 4'hF;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [1:0]  byte_off;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LH  = 3'd1,
        LD_LW  = 3'd2,
        LD_LBU = 3'd4,
        LD_LHU = 3'd5
    } load_type_t;

    // Accesses are naturally aligned, so bits shifted past lane 3 never carry
    // meaning and are dropped.
    function automatic logic [3:0] align_be(input logic [3:0] be, input logic [1:0] off);
        return be << off;
    endfunction

endpackage

// File: rtl/sb_match.sv
// Per-entry overlap detector for the MEM-stage store buffer.
// Ports:
//   entry_valid      in  : entry holds a live store
//   entry_word_addr  in  : entry word address (byte address [31:2])
//   entry_byte_off   in  : entry byte offset (byte address [1:0])
//   entry_be         in  : entry byte enables, lane-0 aligned
//   ld_addr          in  : load byte address
//   ld_be            in  : load byte enables, lane-0 aligned
//   match            out : live entry in the same word sharing at least one byte with the load
//   mask             out : entry byte enables moved onto their real lanes
module sb_match
    import rv32_mem_pkg::*;
(
    input  logic        entry_valid,
    input  logic [29:0] entry_word_addr,
    input  logic [1:0]  entry_byte_off,
    input  logic [3:0]  entry_be,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_be,
    output logic        match,
    output logic [3:0]  mask
);

    logic [3:0] ld_mask;

    assign mask    = align_be(entry_be, entry_byte_off);
    assign ld_mask = align_be(ld_be, ld_addr[1:0]);
    assign match   = entry_valid
                  && (entry_word_addr == ld_addr[31:2])
                  && ((mask & ld_mask) != 4'h0);

endmodule

// File: rtl/store_buffer_mem.sv
// MEM-stage store buffer: a small FIFO of committed stores that drains into the
// single-ported data cache in cycles where no load owns the port. Loads that
// overlap a buffered store stall until the store has drained, or, when built
// with SB_STORE_FWD_EN defined, are served directly from the buffer when every
// requested byte is covered.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   bubbleM, flushM                  : MEM bubble / flush, both suppress the current request
//   st_valid, st_addr, st_data, st_be: incoming store (lane-0 aligned data and enables)
//   ld_valid, ld_addr, ld_be         : incoming load
//   cache_write_en/addr/in_data      : drain port towards the data cache
//   fwd_valid, fwd_data              : forwarded load data (SB_STORE_FWD_EN only, else 0)
//   stall_req                        : stall request to the hazard unit
//   sb_empty, sb_full                : buffer occupancy flags
module store_buffer_mem
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bubbleM,
    input  logic        flushM,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_be,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [3:0]  ld_be,
    output logic [3:0]  cache_write_en,
    output logic [31:0] cache_addr,
    output logic [31:0] cache_in_data,
    output logic        fwd_valid,
    output logic [31:0] fwd_data,
    output logic        stall_req,
    output logic        sb_empty,
    output logic        sb_full
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    sb_entry_t        entries_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   count_reg, count_next;

    logic [DEPTH-1:0] match_vec;
    logic [3:0]       mask_vec [DEPTH];

    sb_entry_t head;
    logic      req_ok;
    logic      ld_req;
    logic      any_match;
    logic      ld_hazard;
    logic      push;
    logic      drain_en;

    assign sb_empty = (count_reg == '0);
    assign sb_full  = (count_reg == FULL_CNT);
    assign head     = entries_reg[rd_ptr_reg];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        sb_match u_match (
            .entry_valid     (valid_reg[gi]),
            .entry_word_addr (entries_reg[gi].word_addr),
            .entry_byte_off  (entries_reg[gi].byte_off),
            .entry_be        (entries_reg[gi].be),
            .ld_addr         (ld_addr),
            .ld_be           (ld_be),
            .match           (match_vec[gi]),
            .mask            (mask_vec[gi])
        );
    end

    assign req_ok    = !bubbleM && !flushM;
    assign ld_req    = ld_valid && req_ok;
    assign any_match = |match_vec;

`ifdef SB_STORE_FWD_EN
    logic [31:0] shifted_data [DEPTH];
    logic [31:0] merged_data;
    logic [3:0]  merged_mask;
    logic [3:0]  ld_mask;
    logic        covered;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        assign shifted_data[gi] = entries_reg[gi].data << {entries_reg[gi].byte_off, 3'b000};
    end

    // Walk from the head (oldest) towards the tail so younger stores
    // overwrite older bytes: the youngest writer of each byte wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = '0;
        merged_data = '0;
        merged_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_reg + PTR_W'(k);
            if (match_vec[idx]) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_vec[idx][b]) begin
                        merged_data[8*b +: 8] = shifted_data[idx][8*b +: 8];
                    end
                end
                merged_mask = merged_mask | mask_vec[idx];
            end
        end
    end

    assign ld_mask   = align_be(ld_be, ld_addr[1:0]);
    assign covered   = ((merged_mask & ld_mask) == ld_mask);
    assign ld_hazard = ld_req && any_match && !covered;
    assign fwd_valid = ld_req && any_match && covered;
    assign fwd_data  = fwd_valid ? (merged_data >> {ld_addr[1:0], 3'b000}) : 32'h0;
`else
    // Byte masks are only consumed by the forwarding merge.
    logic [3:0] unused_mask;
    always_comb begin
        unused_mask = '0;
        for (int k = 0; k < DEPTH; k++) begin
            unused_mask = unused_mask ^ mask_vec[k];
        end
    end

    assign ld_hazard = ld_req && any_match;
    assign fwd_valid = 1'b0;
    assign fwd_data  = 32'h0;
`endif

    assign stall_req = (st_valid && sb_full) || ld_hazard;

    // A stalled load frees the cache port, which is what lets the
    // conflicting store drain and the stall resolve.
    assign drain_en = !sb_empty && (!ld_valid || stall_req);
    assign push     = st_valid && req_ok && !sb_full;

    always_comb begin
        cache_write_en = '0;
        cache_addr     = '0;
        cache_in_data  = '0;
        if (drain_en) begin
            cache_write_en = head.be;
            cache_addr     = {head.word_addr, head.byte_off};
            cache_in_data  = head.data;
        end
    end

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (drain_en) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        case ({push, drain_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_reg[i] <= '0;
            end
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            // Push and pop never target the same slot: that would need the
            // buffer to be both empty and full.
            if (drain_en) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
            if (push) begin
                valid_reg[wr_ptr_reg]   <= 1'b1;
                entries_reg[wr_ptr_reg] <= '{word_addr: st_addr[31:2],
                                             byte_off:  st_addr[1:0],
                                             data:      st_data,
                                             be:        st_be};
            end
        end
    end

endmodule

// File: doc/store_buffer_mem.md
Name: store_buffer_mem

Overview:
- Small FIFO of committed stores sitting in the MEM stage, directly upstream of the MEM/WB write-back data segment register and its Data Cache port.
- Decouples store issue from the single-ported cache: stores enter the buffer and drain to the cache in cycles when no load uses the port.
- Detects load/store address overlap and stalls, or forwards when the feature is enabled, so loads never read stale cache data.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, >= 2)
- PTR_W, $clog2(DEPTH), read/write pointer width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- bubbleM  in  1  MEM stage bubble; holds the incoming request (no push, no load lookup)
- flushM  in  1  MEM stage flush; squashes the incoming request
- st_valid  in  1  store request this cycle
- st_addr  in  32  store byte address
- st_data  in  32  store data, lane 0 aligned (unshifted)
- st_be  in  4  store byte enables, lane 0 aligned (1/3/F)
- ld_valid  in  1  load request this cycle
- ld_addr  in  32  load byte address
- ld_be  in  4  load byte enables, lane 0 aligned
- cache_write_en  out  4  to Data Cache write_en (lane 0 aligned; cache shifts by addr[1:0])
- cache_addr  out  32  to Data Cache addr (full byte address of draining store)
- cache_in_data  out  32  to Data Cache in_data (unshifted)
- fwd_valid  out  1  load fully served from buffer (feature only)
- fwd_data  out  32  forwarded word, lane-aligned (feature only)
- stall_req  out  1  request to hazard unit to stall IF..MEM
- sb_empty  out  1  buffer empty
- sb_full  out  1  buffer full

Behaviour:
- Entries hold {word_addr[31:2], byte_off[1:0], data, be}. Circular FIFO with rd_ptr, wr_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits).
- Reset: all entries invalid, pointers and count = 0. Outputs: cache_write_en = 0, cache_addr = 0, cache_in_data = 0, stall_req = 0, fwd_valid = 0, fwd_data = 0, sb_empty = 1, sb_full = 0. Reset mid-drain discards all buffered stores.
- Request qualifier: req_ok = !bubbleM && !flushM.
- Push: occurs at posedge when st_valid && req_ok && !sb_full, using sb_full as registered at the start of the cycle. If st_valid && sb_full, stall_req = 1 and nothing is pushed.
- Overlap: a valid entry matches a load when word_addr == ld_addr[31:2] and its shifted be AND the shifted ld_be is nonzero.
- Load hazard: ld_valid && req_ok && any entry matches → stall_req = 1.
- Drain: combinational, from the head entry. Enabled when !sb_empty && (!ld_valid || stall_req). When enabled, drive cache_write_en/addr/in_data from the head and pop at posedge; otherwise cache_write_en = 0.
- Throughput: at most one drain per cycle, so latency from push to cache write is >= 1 cycle.
- Simultaneous push and pop: count unchanged. When full with pop and st_valid in the same cycle, there is still no push that cycle; stall resolves next cycle.
- flushM does not clear buffered entries (they are architecturally committed); it only squashes the current request.
- stall_req is combinational. It deasserts in the cycle the last matching entry has drained, i.e. after the pop edge.

Optional Feature:
- Macro: SB_STORE_FWD_EN.
- Defined:
  - Youngest-first byte merge across all matching entries.
  - If the merged mask covers every requested byte: fwd_valid = 1, fwd_data = merged word shifted right by 8*ld_addr[1:0], and no stall for that load.
  - Partial coverage still stalls.
- Undefined: fwd_valid and fwd_data are tied 0; every overlap stalls.

Decomposition:
- Shared package rv32_mem_pkg:
  - byte-enable constants BE_BYTE = 4'h1, BE_HALF = 4'h3, BE_WORD = 4'hF
  - sb_entry_t struct
  - load_type encodings shared with the data extender
- Sub-module sb_match: per-entry compare returning match and aligned byte mask. Instantiated DEPTH times by generate.

Test Plan:
- Reset → sb_empty = 1, cache_write_en = 0; then sw 0x11223344 @0x100, no loads → next cycle cache_write_en = F, cache_addr = 0x100, cache_in_data = 0x11223344; buffer empty the following cycle.
- Five sw with ld_valid held 1 to block drain (DEPTH = 4) → sb_full after the 4th push; stall_req = 1 on the 5th; drop ld_valid → one drain per cycle, 5th store accepted once count < 4.
- sb 0xAB @0x203, then lw @0x200 next cycle → stall_req = 1 until the entry drains (cache_write_en = 1, cache_addr = 0x203), then 0.
- Store @0x300 with flushM = 1 → no push, count unchanged; with bubbleM = 1 → no push.
- SB_STORE_FWD_EN: sw 0xDEADBEEF @0x40, then lh @0x42 → fwd_valid = 1, fwd_data[15:0] = 0xDEAD, stall_req = 0. Then sb 0x55 @0x41 and lw @0x40 → fwd_data = 0xDEAD55EF.
- Push and pop in the same cycle at count = 2 → count stays 2; pointers wrap from 3 to 0 correctly over 8 consecutive stores.
